// File: rtl/ttl_74169a.sv
// ttl_74169a: synchronous up/down binary counter with parallel load and
// active-low ripple-carry/borrow output for cascading.
// Optional feature macro: TTL_PROP_DELAY_EN adds DELAY_RISE/DELAY_FALL
// transport delays on Q and RCO_bar (simulation only); otherwise outputs
// are zero-delay and the delay parameters have no effect.
module ttl_74169a #(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             ENP_bar,
  input  logic             ENT_bar,
  input  logic             U_D,
  input  logic [WIDTH-1:0] D,
  output logic             RCO_bar,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_terminal;
  logic             w_rco_bar;

  // Next counter value: load wins, then count when both enables are low.
  always_comb begin
    w_q_next = r_q;
    if (!Load_bar) begin
      w_q_next = D;
    end else if (!ENP_bar && !ENT_bar) begin
      if (U_D) begin
        w_q_next = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        w_q_next = r_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Counter register; Clear_bar forces zero without waiting for Clk.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Terminal count depends on direction, so U_D changes ripple straight through.
  always_comb begin
    w_terminal = U_D ? (&r_q) : ~(|r_q);
    w_rco_bar  = ~(~ENT_bar & w_terminal);
  end

`ifdef TTL_PROP_DELAY_EN
  // Per-bit transport delay, rise/fall chosen by the new bit value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_q_dly
    always @(r_q[i]) begin
      Q[i] <= #(r_q[i] ? DELAY_RISE : DELAY_FALL) r_q[i];
    end
  end

  // Transport delay on the carry output.
  always @(w_rco_bar) begin
    RCO_bar <= #(w_rco_bar ? DELAY_RISE : DELAY_FALL) w_rco_bar;
  end
`else
  logic w_unused_delays;
  assign w_unused_delays = (DELAY_RISE != DELAY_FALL);
  assign Q       = r_q;
  assign RCO_bar = w_rco_bar;
`endif

endmodule

// File: tb/tb_ttl_74169a.sv
// Bench for ttl_74169a: directed scenarios plus randomized stimulus against
// an arithmetic reference model; also exercises a two-stage 8-bit cascade.
module tb_ttl_74169a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_b, ld_b, enp_b, ent_b, ud;
  logic [3:0] d;
  logic [7:0] cd;
  wire        rco_b;
  wire  [3:0] q;
  wire  [3:0] cq_lo, cq_hi;
  wire        c_rco_lo, c_rco_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int m_q;   // model of the 4-bit counter
  int m_c;   // model of the 8-bit cascade

  ttl_74169a #(.WIDTH(4)) dut (
    .Clk(clk), .Clear_bar(clr_b), .Load_bar(ld_b), .ENP_bar(enp_b),
    .ENT_bar(ent_b), .U_D(ud), .D(d), .RCO_bar(rco_b), .Q(q)
  );

  ttl_74169a #(.WIDTH(4)) u_lo (
    .Clk(clk), .Clear_bar(clr_b), .Load_bar(ld_b), .ENP_bar(enp_b),
    .ENT_bar(ent_b), .U_D(ud), .D(cd[3:0]), .RCO_bar(c_rco_lo), .Q(cq_lo)
  );

  ttl_74169a #(.WIDTH(4)) u_hi (
    .Clk(clk), .Clear_bar(clr_b), .Load_bar(ld_b), .ENP_bar(enp_b),
    .ENT_bar(c_rco_lo), .U_D(ud), .D(cd[7:4]), .RCO_bar(c_rco_hi), .Q(cq_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected carry: low only at the terminal value for the direction, gated by ENT.
  function automatic logic exp_rco(int qv, int maxv, logic ent, logic up);
    if (!ent && ((up && qv == maxv) || (!up && qv == 0))) return 1'b0;
    return 1'b1;
  endfunction

  // Model the effect of one rising edge with the present inputs.
  task automatic model_edge();
    int n;
    if (!clr_b) begin
      m_q = 0; m_c = 0;
    end else if (!ld_b) begin
      m_q = int'(d); m_c = int'(cd);
    end else if (!enp_b && !ent_b) begin
      n   = ud ? 1 : -1;
      m_q = (m_q + n + 16) % 16;
      m_c = (m_c + n + 256) % 256;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"},   {28'b0, q}, m_q);
    check({tag, "_rco"}, {31'b0, rco_b}, {31'b0, exp_rco(m_q, 15, ent_b, ud)});
    check({tag, "_cas"}, {24'b0, cq_hi, cq_lo}, m_c);
  endtask

  task automatic load4(input logic [3:0] v);
    ld_b = 1'b0; d = v; tick(); ld_b = 1'b1;
  endtask

  initial begin
    clr_b = 1'b0; ld_b = 1'b1; enp_b = 1'b0; ent_b = 1'b0; ud = 1'b0;
    d = 4'h0; cd = 8'h00;
    m_q = 0; m_c = 0;
    @(posedge clk); #1;

    // Reset state and reset carry behaviour
    check("rst_q", {28'b0, q}, 32'h0);
    check("rst_rco_down", {31'b0, rco_b}, 32'h0);
    ud = 1'b1; #1;
    check("rst_rco_up", {31'b0, rco_b}, 32'h1);
    ud = 1'b0; ent_b = 1'b1; #1;
    check("rst_rco_ent", {31'b0, rco_b}, 32'h1);
    ent_b = 1'b0;
    ld_b = 1'b0; d = 4'h7; @(posedge clk); #1;
    check("rst_over_load", {28'b0, q}, 32'h0);
    #2 clr_b = 1'b1; ld_b = 1'b1;
    tick();

    // Load then count down through zero
    load4(4'h3);
    check("load3", {28'b0, q}, 32'h3);
    enp_b = 1'b0; ent_b = 1'b0; ud = 1'b0;
    tick(); tick(); tick();
    check("down_q0", {28'b0, q}, 32'h0);
    check("down_rco0", {31'b0, rco_b}, 32'h0);
    tick();
    check("down_wrap", {28'b0, q}, 32'hF);
    check("down_wrap_rco", {31'b0, rco_b}, 32'h1);

    // Count up through all ones
    load4(4'hE); ud = 1'b1;
    tick();
    check("up_qF", {28'b0, q}, 32'hF);
    check("up_rcoF", {31'b0, rco_b}, 32'h0);
    tick();
    check("up_wrap", {28'b0, q}, 32'h0);
    check("up_wrap_rco", {31'b0, rco_b}, 32'h1);

    // Hold and ENT gating
    load4(4'hF); enp_b = 1'b1; ent_b = 1'b0;
    tick();
    check("hold_enp_q", {28'b0, q}, 32'hF);
    check("hold_enp_rco", {31'b0, rco_b}, 32'h0);
    enp_b = 1'b0; ent_b = 1'b1;
    tick();
    check("hold_ent_q", {28'b0, q}, 32'hF);
    check("hold_ent_rco", {31'b0, rco_b}, 32'h1);
    ld_b = 1'b0; d = 4'h5; enp_b = 1'b1; ent_b = 1'b1; ud = 1'b0;
    tick(); ld_b = 1'b1;
    check("load_prio", {28'b0, q}, 32'h5);

    // Direction flip without clock
    load4(4'h0); ent_b = 1'b0; enp_b = 1'b1; ud = 1'b1; #1;
    check("flip_up", {31'b0, rco_b}, 32'h1);
    ud = 1'b0; #1;
    check("flip_down", {31'b0, rco_b}, 32'h0);

    // Asynchronous clear mid-count
    load4(4'h9); enp_b = 1'b0; ent_b = 1'b0; ud = 1'b1;
    #1 clr_b = 1'b0; #1;
    check("aclr_q", {28'b0, q}, 32'h0);
    #1 clr_b = 1'b1;
    m_q = 0; m_c = 0;
    tick();
    check("aclr_next", {28'b0, q}, 32'h1);

    // Cascade down across the nibble boundary
    ld_b = 1'b0; cd = 8'h10; ud = 1'b0; tick(); ld_b = 1'b1;
    check("cas_load", {24'b0, cq_hi, cq_lo}, 32'h10);
    tick();
    check("cas_0F", {24'b0, cq_hi, cq_lo}, 32'h0F);
    tick();
    check("cas_0E", {24'b0, cq_hi, cq_lo}, 32'h0E);
    ld_b = 1'b0; cd = 8'h00; tick(); ld_b = 1'b1;
    tick();
    check("cas_FF", {24'b0, cq_hi, cq_lo}, 32'hFF);

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      ld_b  = ($urandom_range(0, 5) != 0);
      enp_b = ($urandom_range(0, 3) == 0);
      ent_b = ($urandom_range(0, 3) == 0);
      ud    = 1'($urandom_range(0, 1));
      d     = 4'($urandom);
      cd    = 8'($urandom);
      #1;
      check("rnd_rco_pre", {31'b0, rco_b}, {31'b0, exp_rco(m_q, 15, ent_b, ud)});
      if ($urandom_range(0, 30) == 0) begin
        clr_b = 1'b0; #1;
        m_q = 0; m_c = 0;
        check_model("rnd_clr");
        clr_b = 1'b1;
      end
      tick();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
